music_box_state_sequencer: RTL and testbench

Top-level sequencer that owns `currentState` for the music box. It grants one user request at a time to the per-state modules (state 1..NUM_STATES), waits for that module's `stateComplete`, and returns to DoNothing (state 0). It also provides abort and watchdog-timeout exits, and holds off re-triggering while buttons remain pressed. It sits between the debounced button inputs and every `MusicBoxState_*` module, all on `clock_50Mhz`.

---
 rtl/music_box_state_sequencer.sv | 125 ++++++++++++
 tb/tb_music_box_state_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_box_state_sequencer.sv
// music_box_state_sequencer: owns currentState for the music box and grants
// one request at a time. It waits for completion, abort or watchdog timeout.
// Ports:
//   clock_50Mhz, reset     : clock and synchronous active-high reset
//   requestButtons         : level requests; bit i selects state i+1
//   abortButton            : level abort of the running state
//   stateComplete          : completion levels from the state modules
//   currentState           : active state, 0 = DoNothing
//   busy                   : high while in RUN
//   timeoutFlag            : sticky; set when RUN ended by watchdog
//   debugString            : {fsm[1:0], timeoutFlag, watchdog[28:0]}
module music_box_state_sequencer #(
    parameter int NUM_STATES     = 4,
    parameter int TIMEOUT_CYCLES = 300_000_000
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset,
    input  logic [NUM_STATES-1:0] requestButtons,
    input  logic                  abortButton,
    input  logic [NUM_STATES-1:0] stateComplete,
    output logic [4:0]            currentState,
    output logic                  busy,
    output logic                  timeoutFlag,
    output logic [31:0]           debugString
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [28:0] WD_MAX = 29'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_fsm;
    logic [4:0]            r_cur;
    logic                  r_busy;
    logic                  r_tflag;
    logic [28:0]           r_wd;
    logic [NUM_STATES-1:0] r_scPrev;

    logic                  w_reqHit;
    logic [4:0]            w_reqIdx;
    logic                  w_compEdge;
    logic                  w_wdDone;

    // Lowest set request index wins; scan high to low so the last hit sticks.
    always_comb begin
        w_reqHit = 1'b0;
        w_reqIdx = 5'd0;
        for (int i = NUM_STATES - 1; i >= 0; i--) begin
            if (requestButtons[i]) begin
                w_reqHit = 1'b1;
                w_reqIdx = 5'(i + 1);
            end
        end
    end

    // Only the selected module's rising edge counts as completion.
    always_comb begin
        w_compEdge = 1'b0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (r_cur == 5'(i + 1)) begin
                w_compEdge = stateComplete[i] & ~r_scPrev[i];
            end
        end
    end

    assign w_wdDone = (r_wd == WD_MAX);

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            r_fsm    <= S_IDLE;
            r_cur    <= 5'd0;
            r_busy   <= 1'b0;
            r_tflag  <= 1'b0;
            r_wd     <= 29'd0;
            r_scPrev <= '0;
        end else begin
            r_scPrev <= stateComplete;
            case (r_fsm)
                S_IDLE: begin
                    r_cur <= 5'd0;
                    if (!abortButton && w_reqHit) begin
                        r_fsm   <= S_RUN;
                        r_busy  <= 1'b1;
                        r_cur   <= w_reqIdx;
                        r_wd    <= 29'd0;
                        r_tflag <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_wdDone) begin
                        r_wd <= r_wd + 29'd1;
                    end
                    if (w_compEdge || abortButton || w_wdDone) begin
                        r_fsm  <= S_HOLD;
                        r_busy <= 1'b0;
                        r_cur  <= 5'd0;
                        // Timeout is flagged only when nothing else ended RUN.
                        if (!w_compEdge && !abortButton) begin
                            r_tflag <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    r_cur <= 5'd0;
                    // Wait for full release so a held button cannot retrigger.
                    if (requestButtons == '0 && !abortButton) begin
                        r_fsm <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm  <= S_IDLE;
                    r_busy <= 1'b0;
                    r_cur  <= 5'd0;
                end
            endcase
        end
    end

    assign currentState = r_cur;
    assign busy         = r_busy;
    assign timeoutFlag  = r_tflag;
    assign debugString  = {r_fsm, r_tflag, r_wd};

endmodule

// File: tb/tb_music_box_state_sequencer.sv
// Directed testbench for music_box_state_sequencer.
// NUM_STATES=4, TIMEOUT_CYCLES=100.
module tb_music_box_state_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        abt;
    logic [3:0]  sc;
    logic [4:0]  cur;
    logic        bsy;
    logic        tfl;
    logic [31:0] dbg;

    int asserts = 0;
    int errors  = 0;

    always #10 clk = ~clk;

    music_box_state_sequencer #(
        .NUM_STATES(4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock_50Mhz(clk),
        .reset(rst),
        .requestButtons(req),
        .abortButton(abt),
        .stateComplete(sc),
        .currentState(cur),
        .busy(bsy),
        .timeoutFlag(tfl),
        .debugString(dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'd0; abt = 1'b0; sc = 4'd0;
        step(); step();
        asserts++;
        if (cur !== 5'd0) begin
            $display("FAIL reset_cur got %0d want 0", cur); errors++;
        end
        asserts++;
        if (bsy !== 1'b0 || tfl !== 1'b0) begin
            $display("FAIL reset_flags got busy=%b tf=%b want 0 0", bsy, tfl);
            errors++;
        end
        asserts++;
        if (dbg !== 32'd0) begin
            $display("FAIL reset_dbg got %h want 0", dbg); errors++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        req = 4'b0100;
        step();
        req = 4'd0;
        asserts++;
        if (cur !== 5'd3 || bsy !== 1'b1) begin
            $display("FAIL basic_grant got cur=%0d busy=%b want 3 1", cur, bsy);
            errors++;
        end
        sc[2] = 1'b1;
        step();
        asserts++;
        if (cur !== 5'd0 || bsy !== 1'b0 || dbg[31:30] !== 2'd2) begin
            $display("FAIL basic_done got cur=%0d busy=%b fsm=%0d want 0 0 2",
                     cur, bsy, dbg[31:30]);
            errors++;
        end
        sc[2] = 1'b0;
        step();
        asserts++;
        if (dbg[31:30] !== 2'd0) begin
            $display("FAIL basic_idle got fsm=%0d want 0", dbg[31:30]);
            errors++;
        end
    endtask

    task automatic test_lowest();
        req = 4'b1010;
        step();
        req = 4'd0;
        asserts++;
        if (cur !== 5'd2) begin
            $display("FAIL lowest_idx got %0d want 2", cur); errors++;
        end
        sc[3] = 1'b1;
        step(); step();
        asserts++;
        if (cur !== 5'd2 || bsy !== 1'b1) begin
            $display("FAIL lowest_ignore got cur=%0d busy=%b want 2 1", cur, bsy);
            errors++;
        end
        asserts++;
        if (dbg[28:0] !== 29'd2) begin
            $display("FAIL lowest_wd got %0d want 2", dbg[28:0]); errors++;
        end
        sc = 4'b0010;
        step();
        asserts++;
        if (cur !== 5'd0) begin
            $display("FAIL lowest_done got %0d want 0", cur); errors++;
        end
        sc = 4'd0;
        step();
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        step();
        req = 4'd0;
        for (int k = 0; k < 99; k++) step();
        asserts++;
        if (bsy !== 1'b1 || cur !== 5'd1 || tfl !== 1'b0) begin
            $display("FAIL to_early got busy=%b cur=%0d tf=%b want 1 1 0",
                     bsy, cur, tfl);
            errors++;
        end
        step();
        asserts++;
        if (cur !== 5'd0 || tfl !== 1'b1 || bsy !== 1'b0) begin
            $display("FAIL to_fire got cur=%0d tf=%b busy=%b want 0 1 0",
                     cur, tfl, bsy);
            errors++;
        end
        asserts++;
        if (dbg[28:0] !== 29'd99) begin
            $display("FAIL to_wd got %0d want 99", dbg[28:0]); errors++;
        end
        step();
        asserts++;
        if (tfl !== 1'b1 || dbg[31:30] !== 2'd0) begin
            $display("FAIL to_sticky got tf=%b fsm=%0d want 1 0",
                     tfl, dbg[31:30]);
            errors++;
        end
        req = 4'b0001;
        step();
        req = 4'd0;
        asserts++;
        if (tfl !== 1'b0 || bsy !== 1'b1) begin
            $display("FAIL to_clear got tf=%b busy=%b want 0 1", tfl, bsy);
            errors++;
        end
        abt = 1'b1;
        step();
        abt = 1'b0;
        asserts++;
        if (bsy !== 1'b0 || tfl !== 1'b0) begin
            $display("FAIL to_abort got busy=%b tf=%b want 0 0", bsy, tfl);
            errors++;
        end
        step();
    endtask

    task automatic test_hold();
        req = 4'b0010;
        step();
        sc[1] = 1'b1;
        step();
        for (int k = 0; k < 3; k++) step();
        asserts++;
        if (dbg[31:30] !== 2'd2 || cur !== 5'd0 || bsy !== 1'b0) begin
            $display("FAIL hold_stay got fsm=%0d cur=%0d busy=%b want 2 0 0",
                     dbg[31:30], cur, bsy);
            errors++;
        end
        req = 4'd0;
        sc = 4'd0;
        step();
        asserts++;
        if (dbg[31:30] !== 2'd0) begin
            $display("FAIL hold_release got fsm=%0d want 0", dbg[31:30]);
            errors++;
        end
        step();
        asserts++;
        if (bsy !== 1'b0 || cur !== 5'd0) begin
            $display("FAIL hold_noretrig got busy=%b cur=%0d want 0 0", bsy, cur);
            errors++;
        end
    endtask

    task automatic test_abort();
        req = 4'b0001;
        step();
        req = 4'd0;
        abt = 1'b1;
        sc[0] = 1'b1;
        step();
        asserts++;
        if (bsy !== 1'b0 || tfl !== 1'b0 || dbg[31:30] !== 2'd2) begin
            $display("FAIL abort_run got busy=%b tf=%b fsm=%0d want 0 0 2",
                     bsy, tfl, dbg[31:30]);
            errors++;
        end
        abt = 1'b0;
        sc = 4'd0;
        step();
        abt = 1'b1;
        req = 4'b0100;
        step();
        asserts++;
        if (bsy !== 1'b0 || cur !== 5'd0 || dbg[31:30] !== 2'd0) begin
            $display("FAIL abort_idle got busy=%b cur=%0d fsm=%0d want 0 0 0",
                     bsy, cur, dbg[31:30]);
            errors++;
        end
        abt = 1'b0;
        req = 4'd0;
        step();
    endtask

    task automatic test_reset_midrun();
        req = 4'b0001;
        step();
        req = 4'd0;
        for (int k = 0; k < 57; k++) step();
        asserts++;
        if (dbg[28:0] !== 29'd57 || bsy !== 1'b1) begin
            $display("FAIL mid_wd got wd=%0d busy=%b want 57 1", dbg[28:0], bsy);
            errors++;
        end
        rst = 1'b1;
        sc[0] = 1'b1;
        step();
        asserts++;
        if (cur !== 5'd0 || bsy !== 1'b0 || dbg !== 32'd0) begin
            $display("FAIL mid_reset got cur=%0d busy=%b dbg=%h want 0 0 0",
                     cur, bsy, dbg);
            errors++;
        end
        rst = 1'b0;
        step();
        req = 4'b0001;
        step();
        req = 4'd0;
        step(); step(); step();
        asserts++;
        if (bsy !== 1'b1 || cur !== 5'd1) begin
            $display("FAIL mid_level got busy=%b cur=%0d want 1 1", bsy, cur);
            errors++;
        end
        sc[0] = 1'b0;
        step();
        sc[0] = 1'b1;
        step();
        asserts++;
        if (bsy !== 1'b0 || cur !== 5'd0 || tfl !== 1'b0) begin
            $display("FAIL mid_edge got busy=%b cur=%0d tf=%b want 0 0 0",
                     bsy, cur, tfl);
            errors++;
        end
        sc = 4'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lowest();
        test_timeout();
        test_hold();
        test_abort();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, errors);
        $finish;
    end

endmodule
